// File: rtl/axis_frame_pad_pkg.sv
// Shared types for axis_frame_pad: FSM state encoding, the 26-bit stream beat
// layout and its field widths.
package axis_frame_pad_pkg;

    localparam int DATA_W = 8;
    localparam int ID_W   = 8;
    localparam int DEST_W = 8;
    localparam int USER_W = 1;
    localparam int BEAT_W = DATA_W + 1 + ID_W + DEST_W + USER_W;

    typedef enum logic [1:0] {
        ST_XFER  = 2'd0,
        ST_PAD   = 2'd1,
        ST_TRUNC = 2'd2
    } state_e;

    // Field order matches the frame FIFO so beats can be passed through unchanged
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [ID_W-1:0]   id;
        logic [DEST_W-1:0] dest;
        logic [USER_W-1:0] user;
    } beat_t;

    function automatic beat_t make_beat(
        input logic [DATA_W-1:0] data,
        input logic              last,
        input logic [ID_W-1:0]   id,
        input logic [DEST_W-1:0] dest,
        input logic [USER_W-1:0] user
    );
        beat_t b;
        b.data = data;
        b.last = last;
        b.id   = id;
        b.dest = dest;
        b.user = user;
        return b;
    endfunction

endpackage

// File: rtl/axis_frame_pad_out_reg.sv
// axis_out_reg: single-entry registered AXI-Stream output stage. It exposes
// load_en so the producer knows when a new beat may be written.
module axis_out_reg
    import axis_frame_pad_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_valid_i,
    input  logic [BEAT_W-1:0] beat_i,
    output logic              load_en_o,
    output logic [7:0]        m_axis_tdata_o,
    output logic              m_axis_tkeep_o,
    output logic              m_axis_tvalid_o,
    input  logic              m_axis_tready_i,
    output logic              m_axis_tlast_o,
    output logic [7:0]        m_axis_tid_o,
    output logic [7:0]        m_axis_tdest_o,
    output logic              m_axis_tuser_o
);

    beat_t beat_q, beat_d;
    logic  valid_q, valid_d;

    assign load_en_o = m_axis_tready_i | ~valid_q;

    // Payload only moves when a real beat is written, so it is stable under stall
    always_comb begin
        valid_d = valid_q;
        beat_d  = beat_q;
        if (load_en_o) begin
            valid_d = beat_valid_i;
            if (beat_valid_i) begin
                beat_d = beat_t'(beat_i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    assign m_axis_tvalid_o = valid_q;
    assign m_axis_tdata_o  = beat_q.data;
    assign m_axis_tlast_o  = beat_q.last;
    assign m_axis_tid_o    = beat_q.id;
    assign m_axis_tdest_o  = beat_q.dest;
    assign m_axis_tuser_o  = beat_q.user;
    assign m_axis_tkeep_o  = 1'b1;

endmodule

// File: rtl/axis_frame_pad.sv
// axis_frame_pad: pads AXI-Stream frames shorter than MIN_LEN with PAD_BYTE.
// Define AXIS_FRAME_PAD_TRUNC_EN to also cut frames at MAX_LEN (tuser=1 on the cut beat).
module axis_frame_pad
    import axis_frame_pad_pkg::*;
#(
    parameter int         MIN_LEN   = 60,
    parameter int         MAX_LEN   = 1518,
    parameter int         LEN_WIDTH = 16,
    parameter logic [7:0] PAD_BYTE  = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tkeep,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic [7:0]           s_axis_tid,
    input  logic [7:0]           s_axis_tdest,
    input  logic                 s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tkeep,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [7:0]           m_axis_tid,
    output logic [7:0]           m_axis_tdest,
    output logic                 m_axis_tuser,
    output logic                 status_pad,
    output logic                 status_trunc,
    output logic [LEN_WIDTH-1:0] status_frame_len
);

    localparam logic [LEN_WIDTH-1:0] MIN_L   = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_L   = LEN_WIDTH'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] cnt_inc;
    logic [ID_W-1:0]      pad_id_q, pad_id_d;
    logic [DEST_W-1:0]    pad_dest_q, pad_dest_d;
    logic [USER_W-1:0]    pad_user_q, pad_user_d;
    logic                 pad_q, pad_d;
    logic                 trunc_d;
    logic                 load_en;
    logic                 out_valid;
    beat_t                out_beat;

    // Saturating so very long frames report all-ones instead of wrapping
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + LEN_WIDTH'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        pad_id_d      = pad_id_q;
        pad_dest_d    = pad_dest_q;
        pad_user_d    = pad_user_q;
        pad_d         = 1'b0;
        trunc_d       = 1'b0;
        s_axis_tready = 1'b0;
        out_valid     = 1'b0;
        out_beat      = '0;

        case (state_q)
            ST_XFER: begin
                s_axis_tready = load_en;
                if (s_axis_tvalid && load_en) begin
                    out_valid = 1'b1;
                    out_beat  = make_beat(s_axis_tdata, 1'b0, s_axis_tid,
                                          s_axis_tdest, s_axis_tuser);
                    if (s_axis_tlast && (cnt_inc < MIN_L)) begin
                        pad_id_d   = s_axis_tid;
                        pad_dest_d = s_axis_tdest;
                        pad_user_d = s_axis_tuser;
                        pad_d      = 1'b1;
                        cnt_d      = cnt_inc;
                        state_d    = ST_PAD;
                    end else if (s_axis_tlast) begin
                        out_beat.last = 1'b1;
                        cnt_d         = '0;
                        len_d         = cnt_inc;
`ifdef AXIS_FRAME_PAD_TRUNC_EN
                    end else if (cnt_inc == MAX_L) begin
                        out_beat.last = 1'b1;
                        out_beat.user = 1'b1;
                        trunc_d       = 1'b1;
                        len_d         = MAX_L;
                        cnt_d         = '0;
                        state_d       = ST_TRUNC;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            ST_PAD: begin
                if (load_en) begin
                    out_valid = 1'b1;
                    out_beat  = make_beat(PAD_BYTE, 1'b0, pad_id_q,
                                          pad_dest_q, pad_user_q);
                    if (cnt_inc == MIN_L) begin
                        out_beat.last = 1'b1;
                        len_d         = MIN_L;
                        cnt_d         = '0;
                        state_d       = ST_XFER;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            ST_TRUNC: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end
            end

            default: begin
                state_d = ST_XFER;
                cnt_d   = '0;
            end
        endcase

        // Never accept upstream data while reset is held
        if (!rst) begin
            s_axis_tready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_XFER;
            cnt_q      <= '0;
            len_q      <= '0;
            pad_id_q   <= '0;
            pad_dest_q <= '0;
            pad_user_q <= '0;
            pad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            pad_id_q   <= pad_id_d;
            pad_dest_q <= pad_dest_d;
            pad_user_q <= pad_user_d;
            pad_q      <= pad_d;
        end
    end

`ifdef AXIS_FRAME_PAD_TRUNC_EN
    logic trunc_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            trunc_q <= 1'b0;
        end else begin
            trunc_q <= trunc_d;
        end
    end

    assign status_trunc = trunc_q;

    logic unused_inputs;
    assign unused_inputs = s_axis_tkeep;
`else
    assign status_trunc = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tkeep, trunc_d, MAX_L};
`endif

    assign status_pad       = pad_q;
    assign status_frame_len = len_q;

    axis_out_reg u_out_reg (
        .clk             (clk),
        .rst             (rst),
        .beat_valid_i    (out_valid),
        .beat_i          (out_beat),
        .load_en_o       (load_en),
        .m_axis_tdata_o  (m_axis_tdata),
        .m_axis_tkeep_o  (m_axis_tkeep),
        .m_axis_tvalid_o (m_axis_tvalid),
        .m_axis_tready_i (m_axis_tready),
        .m_axis_tlast_o  (m_axis_tlast),
        .m_axis_tid_o    (m_axis_tid),
        .m_axis_tdest_o  (m_axis_tdest),
        .m_axis_tuser_o  (m_axis_tuser)
    );

endmodule

// File: tb/tb_axis_frame_pad.sv
// Self-checking bench for axis_frame_pad with MIN_LEN=8, MAX_LEN=10.
// Build with AXIS_FRAME_PAD_TRUNC_EN to exercise truncation instead of the long-frame case.
module tb_axis_frame_pad;

    localparam int         TB_MIN  = 8;
    localparam int         TB_MAX  = 10;
    localparam int         TB_LENW = 16;
    localparam logic [7:0] TB_PAD  = 8'h00;

    logic               clk;
    logic               rst;
    logic [7:0]         s_axis_tdata;
    logic               s_axis_tkeep;
    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic               s_axis_tlast;
    logic [7:0]         s_axis_tid;
    logic [7:0]         s_axis_tdest;
    logic               s_axis_tuser;
    logic [7:0]         m_axis_tdata;
    logic               m_axis_tkeep;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               m_axis_tlast;
    logic [7:0]         m_axis_tid;
    logic [7:0]         m_axis_tdest;
    logic               m_axis_tuser;
    logic               status_pad;
    logic               status_trunc;
    logic [TB_LENW-1:0] status_frame_len;

    int          testCount = 0;
    int          failCount = 0;
    int          cycleCnt = 0;
    int          padPulses = 0;
    int          truncPulses = 0;
    bit          randomReady = 0;
    logic [25:0] outQ[$];
    int          outCycle[$];
    logic [25:0] expQ[$];

    axis_frame_pad #(
        .MIN_LEN   (TB_MIN),
        .MAX_LEN   (TB_MAX),
        .LEN_WIDTH (TB_LENW),
        .PAD_BYTE  (TB_PAD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tid       (s_axis_tid),
        .s_axis_tdest     (s_axis_tdest),
        .s_axis_tuser     (s_axis_tuser),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tid       (m_axis_tid),
        .m_axis_tdest     (m_axis_tdest),
        .m_axis_tuser     (m_axis_tuser),
        .status_pad       (status_pad),
        .status_trunc     (status_trunc),
        .status_frame_len (status_frame_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Sink ready: always 1, or a coin flip per cycle when randomReady is set
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor samples on the falling edge, i.e. the values the next rising edge will see
    initial begin
        logic [25:0] curBeat;
        logic [25:0] prevBeat;
        bit          prevStall;
        prevStall = 1'b0;
        prevBeat  = '0;
        forever begin
            @(negedge clk);
            cycleCnt++;
            curBeat = {m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser};
            if (rst) begin
                if (prevStall) begin
                    checkOutput("stallValid", 32'(m_axis_tvalid), 32'd1);
                    checkOutput("stallPayload", 32'(curBeat), 32'(prevBeat));
                end
                if (status_pad) padPulses++;
                if (status_trunc) truncPulses++;
                if (m_axis_tvalid && m_axis_tready) begin
                    outQ.push_back(curBeat);
                    outCycle.push_back(cycleCnt);
                end
                prevStall = m_axis_tvalid && !m_axis_tready;
            end else begin
                prevStall = 1'b0;
            end
            prevBeat = curBeat;
        end
    end

    // Sends one frame; entered and left just after a rising edge
    task automatic applyStimulus(input int n, input logic [7:0] id, input logic [7:0] dest,
                                 input logic user, input logic [7:0] base);
        bit acc;
        int waited;
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 8'(base + i);
            s_axis_tlast  = (i == n - 1);
            s_axis_tid    = id;
            s_axis_tdest  = dest;
            s_axis_tuser  = user;
            s_axis_tkeep  = 1'b1;
            acc    = 1'b0;
            waited = 0;
            while (!acc && waited < 200) begin
                @(negedge clk);
                acc = s_axis_tready;
                @(posedge clk);
                #1;
                waited++;
            end
            if (!acc) begin
                checkOutput("inputAccept timeout", 32'd0, 32'd1);
                s_axis_tvalid = 1'b0;
                return;
            end
        end
    endtask

    task automatic expectFrame(input int n, input logic [7:0] id, input logic [7:0] dest,
                               input logic user, input logic [7:0] base);
        int          total;
        logic [7:0]  data;
        total = (n < TB_MIN) ? TB_MIN : n;
        for (int i = 0; i < total; i++) begin
            data = (i < n) ? 8'(base + i) : TB_PAD;
            expQ.push_back({data, (i == total - 1), id, dest, user});
        end
    endtask

    task automatic waitBeats(input int n);
        int waited;
        waited = 0;
        while (outQ.size() < n && waited < 500) begin
            @(posedge clk);
            #1;
            waited++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkFrame(input string tag);
        int cmpN;
        checkOutput({tag, " count"}, 32'(outQ.size()), 32'(expQ.size()));
        cmpN = (outQ.size() < expQ.size()) ? outQ.size() : expQ.size();
        for (int i = 0; i < cmpN; i++) begin
            checkOutput($sformatf("%s beat%0d", tag, i), 32'(outQ[i]), 32'(expQ[i]));
        end
        outQ.delete();
        outCycle.delete();
        expQ.delete();
    endtask

    initial begin
        int padBase;
        int truncBase;
        rst           = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tid    = '0;
        s_axis_tdest  = '0;
        s_axis_tuser  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rst tdata", 32'(m_axis_tdata), 32'd0);
        checkOutput("rst tlast", 32'(m_axis_tlast), 32'd0);
        checkOutput("rst tid", 32'(m_axis_tid), 32'd0);
        checkOutput("rst tdest", 32'(m_axis_tdest), 32'd0);
        checkOutput("rst tuser", 32'(m_axis_tuser), 32'd0);
        checkOutput("rst tkeep", 32'(m_axis_tkeep), 32'd1);
        checkOutput("rst statusPad", 32'(status_pad), 32'd0);
        checkOutput("rst statusTrunc", 32'(status_trunc), 32'd0);
        checkOutput("rst frameLen", 32'(status_frame_len), 32'd0);
        checkOutput("rst sReady", 32'(s_axis_tready), 32'd0);
        rst = 1'b1;

        $display("[TB] 3-beat frame then 8-beat frame, free-flowing sink");
        padBase = padPulses;
        expectFrame(3, 8'h12, 8'h34, 1'b1, 8'h10);
        expectFrame(8, 8'hA1, 8'hB2, 1'b0, 8'h20);
        applyStimulus(3, 8'h12, 8'h34, 1'b1, 8'h10);
        applyStimulus(8, 8'hA1, 8'hB2, 1'b0, 8'h20);
        s_axis_tvalid = 1'b0;
        waitBeats(16);
        if (outCycle.size() >= 16)
            checkOutput("t1 noBubbles", 32'(outCycle[15] - outCycle[0]), 32'd15);
        checkFrame("t1");
        checkOutput("t1 padPulses", 32'(padPulses - padBase), 32'd1);
        checkOutput("t1 frameLen", 32'(status_frame_len), 32'd8);

        $display("[TB] 7-beat frame (pads one) then 9-beat frame");
        padBase = padPulses;
        expectFrame(7, 8'h21, 8'h43, 1'b0, 8'h30);
        expectFrame(9, 8'h22, 8'h44, 1'b1, 8'hF8);
        applyStimulus(7, 8'h21, 8'h43, 1'b0, 8'h30);
        applyStimulus(9, 8'h22, 8'h44, 1'b1, 8'hF8);
        s_axis_tvalid = 1'b0;
        waitBeats(17);
        checkFrame("t2");
        checkOutput("t2 padPulses", 32'(padPulses - padBase), 32'd1);
        checkOutput("t2 frameLen", 32'(status_frame_len), 32'd9);

        $display("[TB] random sink stalls across pad and data beats");
        padBase   = padPulses;
        truncBase = truncPulses;
        randomReady = 1'b1;
        expectFrame(3, 8'h01, 8'h11, 1'b1, 8'hC0);
        expectFrame(10, 8'h02, 8'h12, 1'b0, 8'hD0);
        expectFrame(1, 8'h03, 8'h13, 1'b1, 8'hE0);
        applyStimulus(3, 8'h01, 8'h11, 1'b1, 8'hC0);
        applyStimulus(10, 8'h02, 8'h12, 1'b0, 8'hD0);
        applyStimulus(1, 8'h03, 8'h13, 1'b1, 8'hE0);
        s_axis_tvalid = 1'b0;
        waitBeats(26);
        randomReady = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkFrame("t3");
        checkOutput("t3 padPulses", 32'(padPulses - padBase), 32'd2);
        checkOutput("t3 truncPulses", 32'(truncPulses - truncBase), 32'd0);
        checkOutput("t3 frameLen", 32'(status_frame_len), 32'd8);

        $display("[TB] reset during padding, then fresh 2-beat frame");
        applyStimulus(3, 8'h77, 8'h88, 1'b0, 8'h50);
        s_axis_tvalid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("t4 tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("t4 statusPad", 32'(status_pad), 32'd0);
        checkOutput("t4 statusTrunc", 32'(status_trunc), 32'd0);
        checkOutput("t4 frameLen", 32'(status_frame_len), 32'd0);
        outQ.delete();
        outCycle.delete();
        expQ.delete();
        padBase = padPulses;
        expectFrame(2, 8'h9A, 8'hBC, 1'b1, 8'h60);
        applyStimulus(2, 8'h9A, 8'hBC, 1'b1, 8'h60);
        s_axis_tvalid = 1'b0;
        waitBeats(8);
        checkFrame("t4");
        checkOutput("t4 padPulses", 32'(padPulses - padBase), 32'd1);
        checkOutput("t4 frameLen", 32'(status_frame_len), 32'd8);

`ifdef AXIS_FRAME_PAD_TRUNC_EN
        $display("[TB] 14-beat frame truncated at 10, then 9-beat frame");
        padBase   = padPulses;
        truncBase = truncPulses;
        for (int i = 0; i < 10; i++) begin
            expQ.push_back({8'(8'h40 + i), (i == 9), 8'h05, 8'h66, (i == 9)});
        end
        expectFrame(9, 8'h06, 8'h67, 1'b0, 8'h80);
        applyStimulus(14, 8'h05, 8'h66, 1'b0, 8'h40);
        applyStimulus(9, 8'h06, 8'h67, 1'b0, 8'h80);
        s_axis_tvalid = 1'b0;
        waitBeats(19);
        checkFrame("t5");
        checkOutput("t5 truncPulses", 32'(truncPulses - truncBase), 32'd1);
        checkOutput("t5 padPulses", 32'(padPulses - padBase), 32'd0);
        checkOutput("t5 frameLen", 32'(status_frame_len), 32'd9);
`else
        $display("[TB] 70000-beat frame, counter saturation");
        begin
            int          errCnt;
            logic [25:0] beat;
            padBase = padPulses;
            outQ.delete();
            outCycle.delete();
            applyStimulus(70000, 8'h01, 8'h02, 1'b0, 8'h00);
            s_axis_tvalid = 1'b0;
            waitBeats(70000);
            checkOutput("t6 count", 32'(outQ.size()), 32'd70000);
            errCnt = 0;
            for (int i = 0; i < outQ.size(); i++) begin
                beat = outQ[i];
                if (beat !== {8'(i), (i == 69999), 8'h01, 8'h02, 1'b0}) errCnt++;
            end
            checkOutput("t6 beatErrors", 32'(errCnt), 32'd0);
            checkOutput("t6 frameLen", 32'(status_frame_len), 32'hFFFF);
            checkOutput("t6 padPulses", 32'(padPulses - padBase), 32'd0);
            checkOutput("t6 truncNever", 32'(truncPulses), 32'd0);
            outQ.delete();
            outCycle.delete();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/axis_frame_pad.md
# axis_frame_pad

Frame-length conditioning stage placed directly downstream of the frame FIFO; it consumes the FIFO's master AXI-Stream output, one 8-bit beat per transfer. Frames shorter than MIN_LEN beats are padded with PAD_BYTE up to MIN_LEN. When truncation is compiled in, frames longer than MAX_LEN are cut at MAX_LEN and flagged via tuser. The block reports per-frame status pulses and the emitted length.

## Interface
- MIN_LEN, 60, minimum emitted frame length in beats (≥1)
- MAX_LEN, 1518, maximum emitted frame length in beats (≥MIN_LEN, <2^LEN_WIDTH)
- LEN_WIDTH, 16, width of beat counter and length status
- PAD_BYTE, 8'h00, tdata value of pad beats
- clk  input  1  single clock, all logic on posedge
- rst  input  1  reset, synchronous, active-low (asserted when 0)
- s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  widths 8/1/1/1/1/8/8/1  slave stream; tready is the only output; tkeep is ignored
- m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  widths 8/1/1/1/1/8/8/1  master stream; tready is the only input; m_axis_tkeep is constant 1
- status_pad  output  1  one-cycle pulse when a frame enters padding
- status_trunc  output  1  one-cycle pulse when a frame is truncated
- status_frame_len  output  LEN_WIDTH  length of the last completed emitted frame

## Operation
- One output register (26-bit beat: data, last, id, dest, user). It loads when load_en = m_axis_tready | ~m_axis_tvalid.
- FSM states: ST_XFER (reset state), ST_PAD, ST_TRUNC. Beat counter cnt counts beats emitted in the current frame.
- ST_XFER: s_axis_tready = load_en. On an accepted beat, copy it to the output register and set cnt = cnt+1.
  - tlast with cnt+1 < MIN_LEN: emit the beat with last=0, latch tid/tdest/tuser, pulse status_pad, go to ST_PAD.
  - tlast with cnt+1 ≥ MIN_LEN: emit with last=1, set cnt←0, status_frame_len←cnt+1.
  - (macro on) no tlast with cnt+1 == MAX_LEN: emit with last=1 and user=1, pulse status_trunc, status_frame_len←MAX_LEN, go to ST_TRUNC.
  - tlast exactly at cnt+1 == MAX_LEN is a normal end, with no truncation.
- ST_PAD: s_axis_tready=0. Each load_en cycle emits tdata=PAD_BYTE with the latched id/dest/user and increments cnt. The beat where cnt+1 == MIN_LEN carries last=1 and updates status_frame_len=MIN_LEN; then cnt←0 and the FSM returns to ST_XFER.
- ST_TRUNC: s_axis_tready=1 and nothing is emitted; input beats are discarded. An accepted tlast returns the FSM to ST_XFER with cnt=0.
- Counter arithmetic is LEN_WIDTH-bit unsigned. With the macro off, cnt saturates at all-ones (no wrap).
- Reset mid-frame: FSM→ST_XFER, cnt=0, m_axis_tvalid=0. The partial frame is abandoned and no tlast is synthesized.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata/tlast/tid/tdest/tuser=0, m_axis_tkeep=1, status_pad=0, status_trunc=0, status_frame_len=0. s_axis_tready=0 while rst==0.
- Latency: a beat accepted at edge N is visible on m_axis from edge N+1.
- Throughput: one beat per cycle with no bubbles, including the ST_XFER↔ST_PAD transitions.
- m_axis_tvalid never deasserts, and m_axis payload never changes, until the beat is accepted.
- Status pulses are asserted for exactly the cycle after the triggering edge.
- status_frame_len updates on the same edge that loads the final (last=1) output beat.

## Configuration
- AXIS_FRAME_PAD_TRUNC_EN defined: MAX_LEN truncation, ST_TRUNC and status_trunc are all active.
- Undefined: ST_TRUNC is unreachable, status_trunc is tied to 0, frames of any length pass unchanged (except padding), and MAX_LEN is ignored.

## Structure
- Package axis_frame_pad_pkg holds: the state enum (ST_XFER/ST_PAD/ST_TRUNC), the packed beat struct (same 26-bit field layout as the frame FIFO), and field-width localparams.
- One sub-module, axis_out_reg: a single-entry registered AXI-Stream stage that provides load_en, holds the beat, and drives m_axis_*.

## Test plan
- 3-beat frame with MIN_LEN=8, free-flowing sink → 8 output beats: 3 data beats then 5 beats of 8'h00; tlast only on beat 8; status_pad one pulse; status_frame_len=8.
- 8-beat frame with MIN_LEN=8 → passes unchanged; no status_pad; status_frame_len=8.
- Macro on, MAX_LEN=10, 14-beat frame tid=8'h5 → 10 beats out, beat 10 has tlast=1 and tuser=1; input beats 11–14 consumed with tready=1; status_trunc one pulse; next frame passes intact.
- Random m_axis_tready (50%) across pad and data beats → output sequence identical to the no-stall case; payload stable while tvalid && !tready.
- rst=0 asserted for one cycle during the PAD phase → the following cycle shows m_axis_tvalid=0 and all status outputs 0; a fresh 2-beat frame is then padded to MIN_LEN correctly.
- Macro off, 70000-beat frame with LEN_WIDTH=16 → all beats pass; cnt saturates at 16'hFFFF; status_frame_len=16'hFFFF.
